// File: rtl/spi_flash_test_pkg.sv
// spi_flash_test_pkg: shared state encoding and defaults for the
// SPI flash erase/program/verify self-test sequencer.
package spi_flash_test_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_ERASE  = 3'd1;
  localparam state_t ST_WRITE  = 3'd2;
  localparam state_t ST_READ   = 3'd3;
  localparam state_t ST_FINISH = 3'd4;

  localparam logic [23:0] DEF_TEST_ADDR    = 24'h000000;
  localparam logic [8:0]  DEF_TEST_SIZE    = 9'd256;
  localparam logic [7:0]  DEF_PATTERN_SEED = 8'h00;

  function automatic logic [7:0] pattern_byte(
    input logic [7:0] seed,
    input logic [7:0] idx
  );
    return seed + idx;
  endfunction

endpackage

// File: rtl/spi_flash_test_seq_if.sv
// spi_flash_test_seq_if: request/ack, address and byte-stream
// signals between the self-test sequencer and the flash controller.
interface spi_flash_test_seq_if;

  logic        flash_sector_erase;
  logic        flash_write;
  logic        flash_read;
  logic        flash_bulk_erase;
  logic        flash_sector_erase_ack;
  logic        flash_write_ack;
  logic        flash_read_ack;
  logic [23:0] flash_sector_addr;
  logic [23:0] flash_write_addr;
  logic [23:0] flash_read_addr;
  logic [8:0]  flash_write_size;
  logic [8:0]  flash_read_size;
  logic        flash_write_data_req;
  logic [7:0]  flash_write_data_in;
  logic [7:0]  flash_read_data_out;
  logic        flash_read_data_valid;

  modport master (
    output flash_sector_erase,
    output flash_write,
    output flash_read,
    output flash_bulk_erase,
    input  flash_sector_erase_ack,
    input  flash_write_ack,
    input  flash_read_ack,
    output flash_sector_addr,
    output flash_write_addr,
    output flash_read_addr,
    output flash_write_size,
    output flash_read_size,
    input  flash_write_data_req,
    output flash_write_data_in,
    input  flash_read_data_out,
    input  flash_read_data_valid
  );

  modport slave (
    input  flash_sector_erase,
    input  flash_write,
    input  flash_read,
    input  flash_bulk_erase,
    output flash_sector_erase_ack,
    output flash_write_ack,
    output flash_read_ack,
    input  flash_sector_addr,
    input  flash_write_addr,
    input  flash_read_addr,
    input  flash_write_size,
    input  flash_read_size,
    output flash_write_data_req,
    input  flash_write_data_in,
    output flash_read_data_out,
    output flash_read_data_valid
  );

endinterface

// File: rtl/spi_flash_pattern_chk.sv
// spi_flash_pattern_chk: on-the-fly readback compare against the
// counting pattern, with shortfall accounting at read completion.
module spi_flash_pattern_chk
  import spi_flash_test_pkg::*;
#(
  parameter logic [8:0] TEST_SIZE    = DEF_TEST_SIZE,
  parameter logic [7:0] PATTERN_SEED = DEF_PATTERN_SEED
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       en,
  input  logic       finalize,
  input  logic [7:0] data,
  input  logic       valid,
  output logic [8:0] err_count,
  output logic [7:0] first_fail_idx,
  output logic       err_zero_next
);

  logic [8:0] rd_cnt_q, rd_cnt_d;
  logic [8:0] err_q, err_d;
  logic [7:0] ff_q, ff_d;
  logic       hit;

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      rd_cnt_q <= '0;
      err_q    <= '0;
      ff_q     <= '0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      err_q    <= err_d;
      ff_q     <= ff_d;
    end
  end

  always_comb begin
    rd_cnt_d = rd_cnt_q;
    err_d    = err_q;
    ff_d     = ff_q;
    hit      = en & valid & (rd_cnt_q < TEST_SIZE);
    if (hit) begin
      if (data != pattern_byte(PATTERN_SEED, rd_cnt_q[7:0])) begin
        err_d = err_q + 9'd1;
        if (err_q == '0) ff_d = rd_cnt_q[7:0];
      end
      rd_cnt_d = rd_cnt_q + 9'd1;
    end
    // bytes never delivered before the read ack count as errors
    if (finalize && rd_cnt_d < TEST_SIZE) begin
      if (err_d == '0) ff_d = rd_cnt_d[7:0];
      err_d = err_d + (TEST_SIZE - rd_cnt_d);
    end
    if (clear) begin
      rd_cnt_d = '0;
      err_d    = '0;
      ff_d     = '0;
    end
  end

  assign err_count      = err_q;
  assign first_fail_idx = ff_q;
  assign err_zero_next  = (err_d == '0);

endmodule

// File: rtl/spi_flash_test_seq.sv
// spi_flash_test_seq: erase / page-program / verify self-test
// sequencer driving the SPI flash controller request/ack port.
module spi_flash_test_seq
  import spi_flash_test_pkg::*;
#(
  parameter logic [23:0] TEST_ADDR    = DEF_TEST_ADDR,
  parameter logic [8:0]  TEST_SIZE    = DEF_TEST_SIZE,
  parameter logic [7:0]  PATTERN_SEED = DEF_PATTERN_SEED
) (
  input  logic                 sys_clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [8:0]           err_count,
  output logic [7:0]           first_fail_idx,
  spi_flash_test_seq_if.master fl
);

  state_t     state_q, state_d;
  logic       in_idle, in_erase, in_write;
  logic       in_read, in_finish;
  logic       start_acc;
  logic       er_q, er_d, wr_q, wr_d, rd_q, rd_d;
  logic       busy_q, busy_d, done_q, done_d;
  logic       pass_q, pass_d;
  logic [7:0] wr_idx_q, wr_idx_d;
  logic [7:0] wdata_q, wdata_d;
  logic       chk_err_zero;

  assign in_idle   = (state_q == ST_IDLE);
  assign in_erase  = (state_q == ST_ERASE);
  assign in_write  = (state_q == ST_WRITE);
  assign in_read   = (state_q == ST_READ);
  assign in_finish = (state_q == ST_FINISH);
  assign start_acc = in_idle & start;

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      er_q     <= 1'b0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      wr_idx_q <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      er_q     <= er_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      wr_idx_q <= wr_idx_d;
      wdata_q  <= wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      in_idle:   if (start) state_d = ST_ERASE;
      in_erase:  if (fl.flash_sector_erase_ack) state_d = ST_WRITE;
      in_write:  if (fl.flash_write_ack) state_d = ST_READ;
      in_read:   if (fl.flash_read_ack) state_d = ST_FINISH;
      in_finish: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // requests and status are registered from the next state
  always_comb begin
    er_d     = (state_d == ST_ERASE);
    wr_d     = (state_d == ST_WRITE);
    rd_d     = (state_d == ST_READ);
    busy_d   = er_d | wr_d | rd_d;
    done_d   = (state_d == ST_FINISH);
    pass_d   = pass_q;
    wr_idx_d = wr_idx_q;
    wdata_d  = wdata_q;
    if (start_acc) begin
      pass_d   = 1'b0;
      wr_idx_d = '0;
    end
    if (done_d) pass_d = chk_err_zero;
    if (in_write && fl.flash_write_data_req) begin
      wdata_d  = pattern_byte(PATTERN_SEED, wr_idx_q);
      wr_idx_d = wr_idx_q + 8'd1;
    end
  end

  spi_flash_pattern_chk #(
    .TEST_SIZE    (TEST_SIZE),
    .PATTERN_SEED (PATTERN_SEED)
  ) u_chk (
    .sys_clk        (sys_clk),
    .rst            (rst),
    .clear          (start_acc),
    .en             (in_read),
    .finalize       (in_read & fl.flash_read_ack),
    .data           (fl.flash_read_data_out),
    .valid          (fl.flash_read_data_valid),
    .err_count      (err_count),
    .first_fail_idx (first_fail_idx),
    .err_zero_next  (chk_err_zero)
  );

  assign fl.flash_sector_erase  = er_q;
  assign fl.flash_write         = wr_q;
  assign fl.flash_read          = rd_q;
  assign fl.flash_bulk_erase    = 1'b0;
  assign fl.flash_sector_addr   = TEST_ADDR;
  assign fl.flash_write_addr    = TEST_ADDR;
  assign fl.flash_read_addr     = TEST_ADDR;
  assign fl.flash_write_size    = TEST_SIZE;
  assign fl.flash_read_size     = TEST_SIZE;
  assign fl.flash_write_data_in = wdata_q;

  assign busy = busy_q;
  assign done = done_q;
  assign pass = pass_q;

endmodule

// File: tb/tb_spi_flash_test_seq.sv
// tb_spi_flash_test_seq: behavioural flash controller with ideal
// memory, randomized timing, and a per-index pass/fail reference.
`timescale 1ns/1ps
module tb_spi_flash_test_seq;

  logic       sys_clk = 1'b0;
  logic       rst     = 1'b1;
  logic       start   = 1'b0;
  logic       sel_b   = 1'b0;
  logic       er_ack  = 1'b0;
  logic       wr_ack  = 1'b0;
  logic       rd_ack  = 1'b0;
  logic       wreq    = 1'b0;
  logic       rvalid  = 1'b0;
  logic [7:0] rdata   = 8'h00;

  always #5 sys_clk = ~sys_clk;

  int n_tests = 0;
  int n_fail  = 0;
  int dn      = 0;
  logic [7:0] mem [0:255];

  spi_flash_test_seq_if ifa ();
  spi_flash_test_seq_if ifb ();

  logic       start_a, start_b;
  logic       busy_a, busy_b, done_a, done_b;
  logic       pass_a, pass_b;
  logic [8:0] ec_a, ec_b;
  logic [7:0] ff_a, ff_b;

  assign start_a = start & ~sel_b;
  assign start_b = start & sel_b;

  assign ifa.flash_sector_erase_ack = er_ack;
  assign ifa.flash_write_ack        = wr_ack;
  assign ifa.flash_read_ack         = rd_ack;
  assign ifa.flash_write_data_req   = wreq;
  assign ifa.flash_read_data_out    = rdata;
  assign ifa.flash_read_data_valid  = rvalid;
  assign ifb.flash_sector_erase_ack = er_ack;
  assign ifb.flash_write_ack        = wr_ack;
  assign ifb.flash_read_ack         = rd_ack;
  assign ifb.flash_write_data_req   = wreq;
  assign ifb.flash_read_data_out    = rdata;
  assign ifb.flash_read_data_valid  = rvalid;

  spi_flash_test_seq dut_a (
    .sys_clk        (sys_clk),
    .rst            (rst),
    .start          (start_a),
    .busy           (busy_a),
    .done           (done_a),
    .pass           (pass_a),
    .err_count      (ec_a),
    .first_fail_idx (ff_a),
    .fl             (ifa)
  );

  spi_flash_test_seq #(
    .TEST_ADDR    (24'h012300),
    .TEST_SIZE    (9'd3),
    .PATTERN_SEED (8'hFE)
  ) dut_b (
    .sys_clk        (sys_clk),
    .rst            (rst),
    .start          (start_b),
    .busy           (busy_b),
    .done           (done_b),
    .pass           (pass_b),
    .err_count      (ec_b),
    .first_fail_idx (ff_b),
    .fl             (ifb)
  );

  wire       o_busy  = sel_b ? busy_b : busy_a;
  wire       o_done  = sel_b ? done_b : done_a;
  wire       o_pass  = sel_b ? pass_b : pass_a;
  wire [8:0] o_err   = sel_b ? ec_b : ec_a;
  wire [7:0] o_ff    = sel_b ? ff_b : ff_a;
  wire       o_er    = sel_b ? ifb.flash_sector_erase : ifa.flash_sector_erase;
  wire       o_wr    = sel_b ? ifb.flash_write : ifa.flash_write;
  wire       o_rd    = sel_b ? ifb.flash_read : ifa.flash_read;
  wire       o_bulk  = sel_b ? ifb.flash_bulk_erase : ifa.flash_bulk_erase;
  wire [7:0] o_wdata = sel_b ? ifb.flash_write_data_in : ifa.flash_write_data_in;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge sys_clk);
    if (o_done) dn++;
    chk("one_req", 32'($countones({o_er, o_wr, o_rd}) <= 1), 1);
    chk("bulk_zero", o_bulk, 0);
  endtask

  task automatic run_test(input bit b, input int corrupt, input int nvalid,
                          input bit poke, input int rst_at);
    int         size, budget, nreq, exp_err, exp_ff;
    logic [7:0] seed, d;
    logic [7:0] wq[$];
    logic [7:0] rs[$];
    size  = b ? 3 : 256;
    seed  = b ? 8'hFE : 8'h00;
    nreq  = b ? size + 2 : size;
    sel_b = b;
    dn    = 0;

    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_busy", o_busy, 1);
    chk("start_err", o_err, 0);
    chk("start_pass", o_pass, 0);
    chk("start_ff", o_ff, 0);
    chk("erase_req", {o_er, o_wr, o_rd}, 3'b100);
    repeat ($urandom_range(0, 4)) begin
      tick();
      chk("erase_hold", o_er, 1);
    end
    er_ack = 1'b1;
    tick();
    er_ack = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'hFF;
    chk("erase_drop", o_er, 0);

    budget = 0;
    while (!o_wr && budget < 20) begin
      tick();
      budget++;
    end
    chk("write_req", o_wr, 1);
    for (int i = 0; i < nreq; i++) begin
      wreq = 1'b1;
      if (poke && i == 5) start = 1'b1;
      tick();
      wreq  = 1'b0;
      start = 1'b0;
      wq.push_back(o_wdata);
      repeat ($urandom_range(0, 2)) begin
        tick();
        chk("write_hold", o_wr, 1);
      end
    end
    if (poke) chk("poke_busy", o_busy, 1);
    for (int i = 0; i < nreq; i++) begin
      chk("wdata", wq[i], 8'(seed + i));
      if (i < size) mem[i] = wq[i];
    end
    wr_ack = 1'b1;
    tick();
    wr_ack = 1'b0;
    chk("write_drop", o_wr, 0);

    budget = 0;
    while (!o_rd && budget < 20) begin
      tick();
      budget++;
    end
    chk("read_req", o_rd, 1);
    for (int i = 0; i < nvalid; i++) begin
      d = mem[i];
      if (i == corrupt) d = 8'h00;
      rs.push_back(d);
      rdata  = d;
      rvalid = 1'b1;
      tick();
      rvalid = 1'b0;
      if (rst_at == i + 1) begin
        rst = 1'b1;
        #1;
        chk("rst_req", {o_er, o_wr, o_rd}, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        chk("rst_err", o_err, 0);
        tick();
        rst = 1'b0;
        tick();
        chk("rst_no_done", dn, 0);
        return;
      end
      repeat ($urandom_range(0, 2)) begin
        tick();
        chk("read_hold", o_rd, 1);
      end
    end

    // reference: every index that is missing or wrong is one error
    exp_err = 0;
    exp_ff  = 0;
    for (int i = 0; i < size; i++) begin
      if (i >= nvalid || rs[i] != 8'(seed + i)) begin
        if (exp_err == 0) exp_ff = i;
        exp_err++;
      end
    end

    rd_ack = 1'b1;
    tick();
    rd_ack = 1'b0;
    chk("done", o_done, 1);
    chk("busy_fin", o_busy, 0);
    chk("req_fin", {o_er, o_wr, o_rd}, 0);
    chk("pass", o_pass, 32'(exp_err == 0));
    chk("err_count", o_err, exp_err);
    chk("first_fail", o_ff, exp_ff);
    tick();
    chk("done_once", dn, 1);
    chk("done_drop", o_done, 0);
    chk("pass_hold", o_pass, 32'(exp_err == 0));
  endtask

  initial begin
    int rb;
    tick();
    tick();
    chk("rst_busy0", o_busy, 0);
    chk("rst_done0", o_done, 0);
    chk("rst_pass0", o_pass, 0);
    chk("rst_err0", o_err, 0);
    chk("rst_ff0", o_ff, 0);
    chk("rst_reqs0", {o_er, o_wr, o_rd}, 0);
    chk("rst_wdata0", o_wdata, 0);
    chk("a_addr", ifa.flash_write_addr, 24'h000000);
    chk("a_size", ifa.flash_read_size, 9'd256);
    chk("b_addr", ifb.flash_sector_addr, 24'h012300);
    chk("b_size", ifb.flash_write_size, 9'd3);
    rst = 1'b0;
    tick();

    run_test(0, -1, 256, 0, 0);
    run_test(0, 17, 256, 0, 0);
    run_test(0, -1, 256, 1, 0);
    run_test(0, -1, 250, 0, 0);
    run_test(1, -1, 4, 0, 0);
    run_test(0, -1, 256, 0, 10);
    run_test(0, -1, 256, 0, 0);
    for (int k = 0; k < 4; k++) begin
      rb = int'($urandom_range(0, 1));
      if (rb == 1)
        run_test(1, int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 4)), 0, 0);
      else
        run_test(0, int'($urandom_range(0, 255)),
                 int'($urandom_range(240, 256)), 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
